tdm_secure_ram: RTL and testbench
=================================

Name: tdm_secure_ram

Overview:
- Parametrised dual-slave Avalon-MM on-chip RAM: two independent ports, s1 and s2, share one storage array.
- Adds over the current single-port data memory:
  - configurable width, depth and read latency;
  - readdatavalid and waitrequest signalling;
  - defined collision rules;
  - a hardware zeroization engine that wipes key/plaintext buffers on request or on reset.
- Sits on the encryption datapath bus as the shared key/data buffer between the Nios master (s1) and the cipher engine (s2).

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8; BE_WIDTH = DATA_WIDTH/8
ADDR_WIDTH, 12, word address width
DEPTH, 4096, number of words; 2 <= DEPTH <= 2**ADDR_WIDTH
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2
CLEAR_ON_RESET, 1, 1 = start a zeroization sweep automatically after reset deasserts

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
reset_req  in  1  freezes the block while high (memory, read pipeline, clear FSM)
clken  in  1  clock enable; freezes the block while low
s1_address  in  ADDR_WIDTH  port 1 word address
s1_chipselect  in  1  port 1 select
s1_read  in  1  port 1 read request
s1_write  in  1  port 1 write request
s1_byteenable  in  BE_WIDTH  port 1 byte lanes
s1_writedata  in  DATA_WIDTH  port 1 write data
s1_readdata  out  DATA_WIDTH  port 1 read data
s1_readdatavalid  out  1  port 1 read data valid
s1_waitrequest  out  1  port 1 stall
s2_address  in  ADDR_WIDTH  port 2 word address
s2_chipselect  in  1  port 2 select
s2_read  in  1  port 2 read request
s2_write  in  1  port 2 write request
s2_byteenable  in  BE_WIDTH  port 2 byte lanes
s2_writedata  in  DATA_WIDTH  port 2 write data
s2_readdata  out  DATA_WIDTH  port 2 read data
s2_readdatavalid  out  1  port 2 read data valid
s2_waitrequest  out  1  port 2 stall
clear_req  in  1  level or pulse; starts a zeroization sweep when sampled in IDLE
clear_busy  out  1  high while the sweep runs
clear_done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high.
- en = clken & ~reset_req.
  - en=0 freezes memory, read pipeline and FSM.
  - Outputs hold their values while frozen.
- Reset values:
  - readdata = 0, readdatavalid = 0, clear_busy = 0, clear_done = 0.
  - waitrequest = 1 on both ports.
  - FSM = IDLE, clear counter = 0.
- Waitrequest: sN_waitrequest = reset | ~en | (state != IDLE).
- Accepts:
  - Read accept = chipselect & read & ~waitrequest.
  - Write accept = chipselect & write & ~waitrequest.
  - read and write both high on the same port: the write is performed and the read is dropped (no readdatavalid).
- Write: applies only the bytes with byteenable = 1; lane k maps to bits [8k+7:8k].
- Read:
  - readdata and readdatavalid are driven exactly READ_LATENCY en-cycles after the accept.
  - readdatavalid is high for one en-cycle per accept.
  - Back-to-back reads are sustained at one per cycle.
  - readdata holds its last value between valids.
- Read-during-write, same port or cross-port, same address: the read returns OLD data.
- Dual write, same address, same cycle: for each byte enabled on both ports, s1 wins; bytes enabled on only one port are taken from that port.
- Address >= DEPTH: the write is dropped; a read returns 0 with a normal readdatavalid.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR: when clear_req = 1, or on the first cycle after reset deasserts when CLEAR_ON_RESET = 1.
  - CLEAR: writes all-zero to word clr_addr on each en-cycle, then increments clr_addr. After writing DEPTH-1 -> DONE. A sweep therefore takes exactly DEPTH en-cycles.
  - DONE: clear_done = 1 for one cycle -> IDLE; clr_addr resets to 0.
  - clear_busy = (state == CLEAR).
  - clear_req is ignored in CLEAR and DONE; it is re-sampled only in IDLE.
- Pending reads at clear start: reads accepted before CLEAR still complete with pre-clear data on schedule.
- Reset mid-sweep:
  - The sweep is aborted with no clear_done pulse.
  - CLEAR_ON_RESET = 1: the sweep restarts from address 0.
  - CLEAR_ON_RESET = 0: returns to IDLE with memory partially cleared.
- Reset does not clear memory contents by itself.
- Storage is a behavioural array, inferable as true dual-port block RAM with byte enables.

Test Plan:
- Write/read, READ_LATENCY = 1: s1 writes 0xDEADBEEF to addr 5 with be = 0xF, then reads addr 5. Expect s1_readdatavalid exactly 1 cycle after the accept, with data 0xDEADBEEF.
- Byte enables, READ_LATENCY = 2: addr 7 holds 0x11223344; s2 writes 0xAABBCCDD with be = 0x5. Reading addr 7 returns 0x11BB33DD, with valid 2 cycles after the accept.
- Collision: the same cycle has s1 writing 0x000000FF be = 0x1 and s2 writing 0xFFFFFF00 be = 0xF to addr 3. Expect addr 3 = 0xFFFFFFFF. A cross-port read of addr 3 in that same cycle returns the old value.
- Zeroization, DEPTH = 16, CLEAR_ON_RESET = 0: fill all words with 0xA5A5A5A5, then pulse clear_req.
  - clear_busy is high for 16 cycles and waitrequest = 1 throughout.
  - clear_done pulses once; all 16 words then read 0.
- Freeze/reset mid-sweep: hold clken = 0 for 3 cycles mid-sweep and the sweep extends by 3 cycles. Assert reset at sweep word 8 (CLEAR_ON_RESET = 1): expect no clear_done, the sweep restarts at 0 and completes DEPTH cycles later.
- Out of range, DEPTH = 10, ADDR_WIDTH = 4: a write to addr 12 is dropped; a read of addr 12 returns 0 with readdatavalid.

Source files
------------

// File: rtl/tdm_secure_ram_if.sv
// Avalon-MM slave bus bundle for one port of the shared key/data buffer.
// The same interface type serves both s1 (Nios side) and s2 (cipher engine side).
interface tdm_secure_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] address;
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [BE_WIDTH-1:0]   byteenable;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/tdm_secure_ram.sv
// Dual-slave on-chip RAM shared between the Nios master (s1) and the cipher engine (s2),
// with fixed-latency reads, s1-priority byte collisions and a hardware zeroization sweep.
module tdm_secure_ram #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int DEPTH          = 4096,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reset_req,
    input  logic                   clken,
    tdm_secure_ram_if.slave        s1,
    tdm_secure_ram_if.slave        s2,
    input  logic                   clear_req,
    output logic                   clear_busy,
    output logic                   clear_done
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [IDX_W-1:0]  clr_addr;
    logic [IDX_W-1:0]  clr_addr_nx;
    logic              boot_pend;

    logic              en;
    logic              stall;
    logic              in_range1;
    logic              in_range2;
    logic [IDX_W-1:0]  idx1;
    logic [IDX_W-1:0]  idx2;
    logic              wr_acc1;
    logic              wr_acc2;
    logic              rd_acc1;
    logic              rd_acc2;
    logic              wr_clr;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] rdata1_p0;
    logic [DATA_WIDTH-1:0] rdata2_p0;
    logic                  vld1_p0;
    logic                  vld2_p0;

    assign en    = clken & ~reset_req;
    assign stall = reset | ~en | (state != IDLE);

    assign s1.waitrequest = stall;
    assign s2.waitrequest = stall;

    // Decode: a read that coincides with a write on the same port is dropped.
    assign in_range1 = {1'b0, s1.address} < DEPTH_L;
    assign in_range2 = {1'b0, s2.address} < DEPTH_L;
    assign idx1      = s1.address[IDX_W-1:0];
    assign idx2      = s2.address[IDX_W-1:0];
    assign wr_acc1   = s1.chipselect & s1.write & ~stall;
    assign wr_acc2   = s2.chipselect & s2.write & ~stall;
    assign rd_acc1   = s1.chipselect & s1.read & ~s1.write & ~stall;
    assign rd_acc2   = s2.chipselect & s2.read & ~s2.write & ~stall;
    assign wr_clr    = en & ~reset & (state == CLEAR);

    // Storage: s1 lanes are applied after s2 lanes so s1 wins overlapping bytes.
    always_ff @(posedge clk) begin
        if (wr_clr) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (wr_acc2 && in_range2 && s2.byteenable[b]) begin
                    mem[idx2][8*b +: 8] <= s2.writedata[8*b +: 8];
                end
                if (wr_acc1 && in_range1 && s1.byteenable[b]) begin
                    mem[idx1][8*b +: 8] <= s1.writedata[8*b +: 8];
                end
            end
        end
    end

    // Stage p0: array read; sees pre-write contents for same-cycle writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld1_p0   <= 1'b0;
            vld2_p0   <= 1'b0;
            rdata1_p0 <= '0;
            rdata2_p0 <= '0;
        end else if (en) begin
            vld1_p0 <= rd_acc1;
            vld2_p0 <= rd_acc2;
            if (rd_acc1) begin
                rdata1_p0 <= in_range1 ? mem[idx1] : '0;
            end
            if (rd_acc2) begin
                rdata2_p0 <= in_range2 ? mem[idx2] : '0;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] rdata1_p1;
            logic [DATA_WIDTH-1:0] rdata2_p1;
            logic                  vld1_p1;
            logic                  vld2_p1;

            // Stage p1: extra output register; data only moves on a valid.
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld1_p1   <= 1'b0;
                    vld2_p1   <= 1'b0;
                    rdata1_p1 <= '0;
                    rdata2_p1 <= '0;
                end else if (en) begin
                    vld1_p1 <= vld1_p0;
                    vld2_p1 <= vld2_p0;
                    if (vld1_p0) begin
                        rdata1_p1 <= rdata1_p0;
                    end
                    if (vld2_p0) begin
                        rdata2_p1 <= rdata2_p0;
                    end
                end
            end

            assign s1.readdata      = rdata1_p1;
            assign s1.readdatavalid = vld1_p1;
            assign s2.readdata      = rdata2_p1;
            assign s2.readdatavalid = vld2_p1;
        end else begin : g_lat1
            assign s1.readdata      = rdata1_p0;
            assign s1.readdatavalid = vld1_p0;
            assign s2.readdata      = rdata2_p0;
            assign s2.readdatavalid = vld2_p0;
        end
    endgenerate

    // boot_pend marks the first enabled cycle after reset for the auto sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            clr_addr  <= '0;
            boot_pend <= 1'b1;
        end else if (en) begin
            state     <= state_nx;
            clr_addr  <= clr_addr_nx;
            boot_pend <= 1'b0;
        end
    end

    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        clear_busy  = 1'b0;
        clear_done  = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req || ((CLEAR_ON_RESET != 0) && boot_pend)) begin
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                clear_busy  = 1'b1;
                clr_addr_nx = clr_addr + 1'b1;
                if (clr_addr == LAST_IDX) begin
                    state_nx    = DONE;
                    clr_addr_nx = '0;
                end
            end
            DONE: begin
                clear_done  = 1'b1;
                state_nx    = IDLE;
                clr_addr_nx = '0;
            end
            default: begin
                state_nx    = IDLE;
                clr_addr_nx = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_tdm_secure_ram.sv
// Directed bench for tdm_secure_ram: two instances (latency 1 / depth 16, latency 2 / depth 10)
// checked against a bench-side memory model through a read scoreboard.
module tb_tdm_secure_ram;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_a, rst_b, clken_a, clken_b, reset_req, clr_req_a, clr_req_b;
    logic busy_a, done_a, busy_b, done_b;

    tdm_secure_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) a1 ();
    tdm_secure_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) a2 ();
    tdm_secure_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b1 ();
    tdm_secure_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b2 ();

    tdm_secure_ram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(0)
    ) dut_a (
        .clk(clk), .reset(rst_a), .reset_req(reset_req), .clken(clken_a),
        .s1(a1), .s2(a2),
        .clear_req(clr_req_a), .clear_busy(busy_a), .clear_done(done_a)
    );

    tdm_secure_ram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(10), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .reset(rst_b), .reset_req(reset_req), .clken(clken_b),
        .s1(b1), .s2(b2),
        .clear_req(clr_req_b), .clear_busy(busy_b), .clear_done(done_b)
    );

    logic [31:0] ma [16];
    logic [31:0] mb [10];

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input logic [3:0] ad,
                            input logic [3:0] be, input logic [31:0] dt);
        case (p)
            0: begin a1.chipselect = r | w; a1.read = r; a1.write = w; a1.address = ad; a1.byteenable = be; a1.writedata = dt; end
            1: begin a2.chipselect = r | w; a2.read = r; a2.write = w; a2.address = ad; a2.byteenable = be; a2.writedata = dt; end
            2: begin b1.chipselect = r | w; b1.read = r; b1.write = w; b1.address = ad; b1.byteenable = be; b1.writedata = dt; end
            default: begin b2.chipselect = r | w; b2.read = r; b2.write = w; b2.address = ad; b2.byteenable = be; b2.writedata = dt; end
        endcase
    endtask

    task automatic get_port(input int p, output logic cs, output logic r, output logic w,
                            output logic [3:0] ad, output logic [3:0] be, output logic [31:0] dt);
        case (p)
            0: begin cs = a1.chipselect; r = a1.read; w = a1.write; ad = a1.address; be = a1.byteenable; dt = a1.writedata; end
            1: begin cs = a2.chipselect; r = a2.read; w = a2.write; ad = a2.address; be = a2.byteenable; dt = a2.writedata; end
            2: begin cs = b1.chipselect; r = b1.read; w = b1.write; ad = b1.address; be = b1.byteenable; dt = b1.writedata; end
            default: begin cs = b2.chipselect; r = b2.read; w = b2.write; ad = b2.address; be = b2.byteenable; dt = b2.writedata; end
        endcase
    endtask

    task automatic wr(input int p, input logic [3:0] ad, input logic [31:0] dt, input logic [3:0] be);
        set_port(p, 1'b0, 1'b1, ad, be, dt);
    endtask

    task automatic rd(input int p, input logic [3:0] ad);
        set_port(p, 1'b1, 1'b0, ad, 4'h0, 32'h0);
    endtask

    task automatic idle_ports();
        for (int p = 0; p < 4; p++) set_port(p, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    // Reference behaviour for one cycle of one instance: reads see old data, then s2 then s1 writes.
    task automatic model_dut(input int d);
        logic        cs [2];
        logic        r  [2];
        logic        w  [2];
        logic [3:0]  ad [2];
        logic [3:0]  be [2];
        logic [31:0] dt [2];
        int          depth;
        int          rl;
        exp_t        e;
        depth = (d != 0) ? 10 : 16;
        rl    = (d != 0) ? 2 : 1;
        for (int k = 0; k < 2; k++) get_port(2*d + k, cs[k], r[k], w[k], ad[k], be[k], dt[k]);
        for (int k = 0; k < 2; k++) begin
            if (cs[k] && r[k] && !w[k]) begin
                e.port = 2*d + k;
                e.data = (int'(ad[k]) < depth) ? ((d != 0) ? mb[ad[k]] : ma[ad[k]]) : 32'h0;
                e.due  = cyc + rl;
                sb.push_back(e);
            end
        end
        for (int k = 1; k >= 0; k--) begin
            if (cs[k] && w[k] && int'(ad[k]) < depth) begin
                for (int bi = 0; bi < 4; bi++) begin
                    if (be[k][bi]) begin
                        if (d != 0) mb[ad[k]][8*bi +: 8] = dt[k][8*bi +: 8];
                        else        ma[ad[k]][8*bi +: 8] = dt[k][8*bi +: 8];
                    end
                end
            end
        end
    endtask

    task automatic tick();
        if (clken_a && !reset_req && !rst_a) model_dut(0);
        if (clken_b && !reset_req && !rst_b) model_dut(1);
        @(negedge clk);
        idle_ports();
    endtask

    task automatic mon(input int p, input logic v, input logic [31:0] dt);
        int idx;
        idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].port == p) idx = i;
        if (v) begin
            if (idx < 0) begin
                check($sformatf("rvalid_spurious_p%0d", p), {31'b0, v}, 32'h0);
            end else begin
                check($sformatf("rvalid_cycle_p%0d", p), cyc, sb[idx].due);
                check($sformatf("rdata_p%0d", p), dt, sb[idx].data);
                sb.delete(idx);
            end
        end else if (idx >= 0 && sb[idx].due <= cyc) begin
            check($sformatf("rvalid_missing_p%0d", p), {31'b0, v}, 32'h1);
            sb.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        mon(0, a1.readdatavalid, a1.readdata);
        mon(1, a2.readdatavalid, a2.readdata);
        mon(2, b1.readdatavalid, b1.readdata);
        mon(3, b2.readdatavalid, b2.readdata);
    end

    // Observe a sweep at each negedge; optionally freeze dut_a or reset dut_b part-way.
    task automatic sweep(input int d, input int frz_at, input int rst_at,
                         output int busy_n, output int done_n, output int wbad);
        int   post;
        bit   did_rst;
        logic bz, dn, wq;
        post = 0; did_rst = 1'b0;
        busy_n = 0; done_n = 0; wbad = 0;
        for (int i = 0; i < 200 && post < 3; i++) begin
            bz = (d != 0) ? busy_b : busy_a;
            dn = (d != 0) ? done_b : done_a;
            wq = (d != 0) ? b1.waitrequest : a1.waitrequest;
            if (bz) busy_n++;
            if (dn) done_n++;
            if (bz && !wq) wbad++;
            if (done_n > 0) post++;
            if (d == 0) clken_a = !(frz_at > 0 && busy_n >= frz_at && busy_n < frz_at + 3);
            if (d != 0) begin
                rst_b = (rst_at > 0 && busy_n == rst_at && !did_rst);
                if (rst_b) did_rst = 1'b1;
            end
            @(negedge clk);
        end
        clken_a = 1'b1;
        rst_b   = 1'b0;
    endtask

    int bz_n, dn_n, wb_n;

    initial begin
        idle_ports();
        rst_a = 1'b1; rst_b = 1'b1; clken_a = 1'b1; clken_b = 1'b1;
        reset_req = 1'b0; clr_req_a = 1'b0; clr_req_b = 1'b0;
        for (int i = 0; i < 16; i++) ma[i] = 32'h0;
        for (int i = 0; i < 10; i++) mb[i] = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_wait_a1", {31'b0, a1.waitrequest}, 32'h1);
        check("rst_wait_b2", {31'b0, b2.waitrequest}, 32'h1);
        check("rst_rvalid_a1", {31'b0, a1.readdatavalid}, 32'h0);
        check("rst_rdata_b1", b1.readdata, 32'h0);
        check("rst_busy_a", {31'b0, busy_a}, 32'h0);
        check("rst_done_b", {31'b0, done_b}, 32'h0);

        // Release: dut_b starts its automatic sweep, dut_a stays idle
        rst_a = 1'b0; rst_b = 1'b0;
        sweep(1, -1, -1, bz_n, dn_n, wb_n);
        check("boot_sweep_busy", bz_n, 10);
        check("boot_sweep_done", dn_n, 1);
        check("boot_sweep_wait", wb_n, 0);
        check("idle_wait_a1", {31'b0, a1.waitrequest}, 32'h0);

        // Write then read, latency 1, plus back-to-back reads
        wr(0, 4'd5, 32'hDEADBEEF, 4'hF); tick();
        rd(0, 4'd5); tick();
        wr(0, 4'd1, 32'h01010101, 4'hF); wr(1, 4'd2, 32'h02020202, 4'hF); tick();
        rd(1, 4'd1); tick();
        rd(1, 4'd2); rd(0, 4'd5); tick();
        rd(1, 4'd5); tick();

        // Dual write collision on addr 3, then cross-port read-during-write
        wr(0, 4'd3, 32'h12345678, 4'hF); tick();
        wr(0, 4'd3, 32'h000000FF, 4'h1); wr(1, 4'd3, 32'hFFFFFF00, 4'hF); tick();
        rd(0, 4'd3); tick();
        wr(0, 4'd3, 32'hCAFEF00D, 4'hF); rd(1, 4'd3); tick();
        rd(1, 4'd3); tick();
        set_port(1, 1'b1, 1'b1, 4'd3, 4'hF, 32'h55AA55AA); tick();
        rd(1, 4'd3); tick();
        repeat (3) tick();

        // reset_req stalls both ports and blocks accepts
        reset_req = 1'b1;
        #1;
        check("rreq_wait_a2", {31'b0, a2.waitrequest}, 32'h1);
        check("rreq_wait_b1", {31'b0, b1.waitrequest}, 32'h1);
        rd(0, 4'd5); tick();
        reset_req = 1'b0;
        repeat (3) tick();

        // Byte enables, latency 2
        wr(2, 4'd7, 32'h11223344, 4'hF); tick();
        wr(3, 4'd7, 32'hAABBCCDD, 4'h5); tick();
        rd(3, 4'd7); tick();
        rd(2, 4'd7); tick();

        // Out of range on the depth-10 instance
        wr(2, 4'd12, 32'h12345678, 4'hF); tick();
        rd(2, 4'd12); tick();
        wr(3, 4'd9, 32'h99999999, 4'hF); tick();
        rd(3, 4'd9); rd(2, 4'd12); tick();
        repeat (4) tick();

        // Zeroization of dut_a
        for (int i = 0; i < 16; i++) begin wr(0, 4'(i), 32'hA5A5A5A5, 4'hF); tick(); end
        clr_req_a = 1'b1; @(negedge clk); clr_req_a = 1'b0;
        sweep(0, -1, -1, bz_n, dn_n, wb_n);
        check("clr_busy_cycles", bz_n, 16);
        check("clr_done_pulses", dn_n, 1);
        check("clr_wait_low", wb_n, 0);
        for (int i = 0; i < 16; i++) ma[i] = 32'h0;
        for (int i = 0; i < 16; i++) begin rd(1, 4'(i)); tick(); end
        repeat (3) tick();

        // Sweep frozen for 3 cycles by clken
        for (int i = 0; i < 16; i++) begin wr(1, 4'(i), 32'h3C000000 + i, 4'hF); tick(); end
        clr_req_a = 1'b1; @(negedge clk); clr_req_a = 1'b0;
        sweep(0, 5, -1, bz_n, dn_n, wb_n);
        check("frz_busy_cycles", bz_n, 19);
        check("frz_done_pulses", dn_n, 1);
        check("frz_wait_low", wb_n, 0);
        for (int i = 0; i < 16; i++) ma[i] = 32'h0;
        for (int i = 0; i < 16; i++) begin rd(0, 4'(i)); tick(); end
        repeat (3) tick();

        // Reset at sweep word 8 on dut_b: abort without done, restart from 0
        for (int i = 0; i < 10; i++) begin wr(2, 4'(i), 32'h5A5A0000 + i, 4'hF); tick(); end
        clr_req_b = 1'b1; @(negedge clk); clr_req_b = 1'b0;
        sweep(1, -1, 9, bz_n, dn_n, wb_n);
        check("rst_sweep_busy", bz_n, 19);
        check("rst_sweep_done", dn_n, 1);
        check("rst_sweep_wait", wb_n, 0);
        for (int i = 0; i < 10; i++) mb[i] = 32'h0;
        for (int i = 0; i < 10; i++) begin rd(3, 4'(i)); tick(); end
        repeat (4) tick();

        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
